bl_loader: RTL and testbench



---
 rtl/bl_pkg.sv | 19 +
 rtl/bl_byte_asm.sv | 31 +++
 rtl/bl_loader.sv | 179 +++++++++++++++++
 tb/tb_bl_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bl_pkg.sv
// Shared types and constants for the UART bootloader engine.
package bl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    DATA,
    WRITE,
    CSUM,
    VERIFY,
    RESP,
    DONE
  } bl_state_t;

  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/bl_byte_asm.sv
// Little-endian 4-byte assembler; o_done/o_word are valid in the cycle the 4th byte arrives.
module bl_byte_asm (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_done,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sh;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_sh  <= {i_byte, r_sh[23:8]};
    end
  end

  // After three bytes r_sh holds {b2,b1,b0}; the live byte completes the word.
  assign o_done = i_valid && !i_clr && (r_cnt == 2'd3);
  assign o_word = {i_byte, r_sh};

endmodule

// File: rtl/bl_loader.sv
// UART bootloader: receives a framed image, writes it to instruction memory,
// reads it back against a host checksum, answers ACK/NAK and releases the core.
module bl_loader
  import bl_pkg::*;
#(
  parameter int unsigned MAX_WORDS   = 8001,
  parameter int unsigned BASE_WADDR  = 0,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  input  logic [31:0] bl_dout,
  output logic        core_hold,
  output logic        boot_done,
  output logic        err
);

  localparam logic [31:0] BASE = 32'(BASE_WADDR);

  bl_state_t   r_state, w_next;
  logic [31:0] r_count, r_csum, r_acc, r_idx, r_tmo, r_waddr, r_wdata;
  logic [7:0]  r_txdata;
  logic        r_ack, r_err, r_done, r_hold;

  logic        w_in_frame, w_sync, w_tmo, w_last, w_over;
  logic        w_asm_done;
  logic [31:0] w_asm_word, w_acc_next;

  assign w_in_frame = (r_state == CNT) || (r_state == DATA) || (r_state == CSUM);
  // Inside a frame 0xA5 is ordinary payload; an abandoned frame resyncs via timeout.
  assign w_sync     = rx_valid && (rx_data == SYNC_BYTE) &&
                      ((r_state == IDLE) || (r_state == DONE));
  assign w_tmo      = w_in_frame && !rx_valid && (r_tmo == 32'(TIMEOUT_CYC - 1));
  assign w_last     = (r_idx == r_count - 32'd1);
  assign w_over     = (w_asm_word > 32'(MAX_WORDS));
  assign w_acc_next = r_acc + bl_dout;

  bl_byte_asm u_asm (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (!w_in_frame),
    .i_valid (rx_valid),
    .i_byte  (rx_data),
    .o_done  (w_asm_done),
    .o_word  (w_asm_word)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_sync) w_next = CNT;
      CNT: begin
        if (w_tmo) w_next = IDLE;
        else if (w_asm_done) begin
          if (w_over)                  w_next = RESP;
          else if (w_asm_word == '0)   w_next = CSUM;
          else                         w_next = DATA;
        end
      end
      DATA: begin
        if (w_tmo)           w_next = IDLE;
        else if (w_asm_done) w_next = WRITE;
      end
      WRITE:  w_next = w_last ? CSUM : DATA;
      CSUM: begin
        if (w_tmo)           w_next = IDLE;
        else if (w_asm_done) w_next = (r_count == '0) ? RESP : VERIFY;
      end
      VERIFY: if (w_last) w_next = RESP;
      RESP:   if (tx_ready) w_next = r_ack ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count  <= '0;
      r_csum   <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_waddr  <= BASE;
      r_wdata  <= '0;
      r_txdata <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_hold   <= 1'b1;
    end else begin
      if (!w_in_frame || rx_valid) r_tmo <= '0;
      else                         r_tmo <= r_tmo + 32'd1;
      if (w_tmo) r_err <= 1'b1;

      case (r_state)
        IDLE, DONE: begin
          if (w_sync) begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_hold <= 1'b1;
          end
        end
        CNT: begin
          if (w_asm_done) begin
            r_count <= w_asm_word;
            r_idx   <= '0;
            r_waddr <= BASE;
            if (w_over) begin
              r_ack    <= 1'b0;
              r_txdata <= NAK_BYTE;
            end
          end
        end
        DATA: if (w_asm_done) r_wdata <= w_asm_word;
        WRITE: begin
          r_waddr <= r_waddr + 32'd1;
          r_idx   <= r_idx + 32'd1;
        end
        CSUM: begin
          if (w_asm_done) begin
            r_csum  <= w_asm_word;
            r_waddr <= BASE;
            r_acc   <= '0;
            r_idx   <= '0;
            if (r_count == '0) begin
              r_ack    <= (w_asm_word == '0);
              r_txdata <= (w_asm_word == '0) ? ACK_BYTE : NAK_BYTE;
            end
          end
        end
        VERIFY: begin
          r_acc   <= w_acc_next;
          r_waddr <= r_waddr + 32'd1;
          r_idx   <= r_idx + 32'd1;
          if (w_last) begin
            r_ack    <= (w_acc_next == r_csum);
            r_txdata <= (w_acc_next == r_csum) ? ACK_BYTE : NAK_BYTE;
          end
        end
        RESP: begin
          if (tx_ready) begin
            if (r_ack) begin
              r_done <= 1'b1;
              r_hold <= 1'b0;
            end else begin
              r_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = (r_state == WRITE);
  assign mem_rd    = (r_state == VERIFY);
  assign tx_valid  = (r_state == RESP);
  assign tx_data   = r_txdata;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign core_hold = r_hold;
  assign boot_done = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_bl_loader.sv
// Self-checking bench for bl_loader: directed frames plus randomized images
// checked against a checksum/response model and a behavioural memory.
module tb_bl_loader;

  localparam int unsigned MAXW = 8001;
  localparam int unsigned TMO  = 100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic [31:0] bl_dout;
  logic        core_hold;
  logic        boot_done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] fw[$];
  int n_rd = 0;
  int n_both = 0;
  int n_txv = 0;

  always #5 clk = ~clk;

  assign bl_dout = mem[mem_waddr[7:0]];

  bl_loader #(
    .MAX_WORDS   (MAXW),
    .BASE_WADDR  (0),
    .TIMEOUT_CYC (TMO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .bl_dout   (bl_dout),
    .core_hold (core_hold),
    .boot_done (boot_done),
    .err       (err)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_waddr);
      wd_q.push_back(mem_wdata);
      mem[mem_waddr[7:0]] <= mem_wdata;
    end
    if (mem_rd) n_rd++;
    if (mem_we && mem_rd) n_both++;
    if (tx_valid) n_txv++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hold"},  core_hold, 1);
    chk({tag, "_done"},  boot_done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_rd"},    mem_rd, 0);
    chk({tag, "_txv"},   tx_valid, 0);
    chk({tag, "_waddr"}, mem_waddr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_txd"},   tx_data, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(1, 3));
  endtask

  task automatic wait_resp(input int stall, output logic [7:0] got);
    int k = 0;
    bit stable = 1'b1;
    logic [7:0] d0;
    while (tx_valid !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("resp_seen", tx_valid, 1);
    d0 = tx_data;
    repeat (stall) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== d0) stable = 1'b0;
    end
    if (stall > 0) chk("resp_stable", stable, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    got = d0;
    chk("resp_single_hs", tx_valid, 0);
  endtask

  task automatic run_frame(input logic [31:0] cnt, input logic [31:0] csum,
                           input int stall, input string tag);
    logic [31:0] sum = '0;
    logic [7:0]  got;
    bit          ack;
    int          w0 = wa_q.size();
    int          r0 = n_rd;
    send_byte(8'hA5, $urandom_range(1, 3));
    send_word(cnt);
    if (cnt <= MAXW) begin
      foreach (fw[i]) send_word(fw[i]);
      send_word(csum);
    end
    wait_resp(stall, got);
    foreach (fw[i]) sum += fw[i];
    ack = (cnt <= MAXW) && (sum == csum);
    chk({tag, "_resp"}, got, ack ? 8'h06 : 8'h15);
    if (cnt <= MAXW) begin
      chk({tag, "_nwr"}, wa_q.size() - w0, fw.size());
      foreach (fw[i]) begin
        chk({tag, "_waddr"}, wa_q[w0 + i], i);
        chk({tag, "_wdata"}, wd_q[w0 + i], fw[i]);
      end
      chk({tag, "_nrd"}, n_rd - r0, cnt);
    end else begin
      chk({tag, "_nwr"}, wa_q.size() - w0, 0);
      chk({tag, "_nrd"}, n_rd - r0, 0);
    end
    chk({tag, "_done"}, boot_done, ack);
    chk({tag, "_hold"}, core_hold, !ack);
    chk({tag, "_err"},  err, !ack);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cnt, sum, csum;
    int n0;
    foreach (mem[i]) mem[i] = '0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    resetn = 1'b1;
    @(negedge clk);

    // Frame from the test plan, preceded by junk that IDLE must ignore.
    send_byte(8'h00, 1);
    send_byte(8'h13, 1);
    fw = '{32'h0000_0013, 32'h1234_5678};
    run_frame(32'd2, 32'h1234_568B, 0, "good2");

    // Re-load from DONE: sync reasserts hold, then bad checksum NAKs.
    send_byte(8'hA5, 1);
    chk("reload_hold", core_hold, 1);
    chk("reload_done", boot_done, 0);
    cnt = 32'd2;
    send_word(cnt);
    foreach (fw[i]) send_word(fw[i]);
    send_word(32'h0);
    begin
      logic [7:0] got;
      wait_resp(0, got);
      chk("badcs_resp", got, 8'h15);
    end
    chk("badcs_err",  err, 1);
    chk("badcs_hold", core_hold, 1);
    chk("badcs_done", boot_done, 0);

    // Oversized count: immediate NAK with no writes.
    fw.delete();
    run_frame(MAXW + 1, 32'h0, 0, "over");

    // Empty images.
    run_frame(32'd0, 32'h0, 0, "zero_ok");
    run_frame(32'd0, 32'h5, 0, "zero_bad");

    // Largest legal count must not be rejected; abandon it via timeout.
    n0 = n_txv;
    send_byte(8'hA5, 1);
    send_word(MAXW);
    repeat (20) @(negedge clk);
    chk("max_no_nak", n_txv - n0, 0);
    repeat (TMO) @(negedge clk);
    chk("max_tmo_err", err, 1);

    // Timeout after two data bytes.
    n0 = n_txv;
    send_byte(8'hA5, 1);
    send_word(32'd3);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    repeat (TMO - 2) @(negedge clk);
    chk("tmo_early_err", err, 0);
    repeat (3) @(negedge clk);
    chk("tmo_err",  err, 1);
    chk("tmo_hold", core_hold, 1);
    chk("tmo_txv",  n_txv - n0, 0);
    fw = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF};
    run_frame(32'd3, 32'hDEAD_BEEF + 32'h1 + 32'hFFFF_FFFF, 0, "after_tmo");

    // Randomized images, some with corrupted checksums.
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 12);
      fw.delete();
      sum = '0;
      for (int i = 0; i < int'(cnt); i++) begin
        fw.push_back($urandom);
        sum += fw[i];
      end
      csum = ($urandom_range(0, 1) == 1) ? sum : (sum ^ (32'd1 << $urandom_range(0, 31)));
      run_frame(cnt, csum, $urandom_range(0, 4), "rand");
    end

    // Response backpressure.
    fw = '{32'h0BAD_F00D};
    run_frame(32'd1, 32'h0BAD_F00D, 20, "bp");

    // Reset pulse in the middle of DATA.
    send_byte(8'hA5, 1);
    send_word(32'd3);
    send_word(32'hCAFE_0001);
    send_byte(8'h44, 1);
    send_byte(8'h55, 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk_reset_vals("midrst");
    fw = '{32'h0000_0007, 32'h0000_0009};
    run_frame(32'd2, 32'h0000_0010, 0, "after_rst");

    chk("we_rd_exclusive", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
